// File: rtl/mem_rr_arbiter_if.sv
// mem_rr_arbiter_if
//   Bundles the requester-side handshake (req/cmd/gnt/rvalid/err/rdata) and the
//   single-port memory command/return bus for mem_rr_arbiter.
//   slave  : arbiter view (consumes requests and read data, drives grants and memory commands)
//   master : environment view (requesters plus the memory)
interface mem_rr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 11
);
    // requester side
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            wr_rd;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
    logic [NUM_REQ*WIDTH-1:0]      wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rvalid;
    logic [NUM_REQ-1:0]            err;
    logic [WIDTH-1:0]              rdata;

    // memory side
    logic                          mem_en;
    logic                          mem_wr_rd;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [WIDTH-1:0]              mem_wdata;
    logic [WIDTH-1:0]              mem_rdata;

    modport slave (
        input  req, wr_rd, addr, wdata, mem_rdata,
        output gnt, rvalid, err, rdata, mem_en, mem_wr_rd, mem_addr, mem_wdata
    );

    modport master (
        output req, wr_rd, addr, wdata, mem_rdata,
        input  gnt, rvalid, err, rdata, mem_en, mem_wr_rd, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter
//   Round-robin arbiter sharing one single-port synchronous memory among NUM_REQ
//   requesters. One command per cycle is registered onto the memory port; read
//   data returns two cycles after the request with a per-requester valid strobe.
//   Addresses >= DEPTH are granted but never reach the memory and pulse err.
//   Optional feature macro: MEM_ARB_STATS_EN adds stats_clr / grant_cnt
//   (16-bit saturating grant counters per requester).
module mem_rr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DEPTH      = 1600,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_rr_arbiter_if.slave       bus
`ifdef MEM_ARB_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [NUM_REQ*16-1:0] grant_cnt
`endif
);

    localparam int unsigned          PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0]     PTR_RST   = PTR_W'(NUM_REQ - 1);
    localparam logic [ADDR_WIDTH:0]  DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    // registered state
    logic [NUM_REQ-1:0]    gnt_q,       gnt_d;
    logic [NUM_REQ-1:0]    rvalid_q,    rvalid_d;
    logic [NUM_REQ-1:0]    err_q,       err_d;
    logic [PTR_W-1:0]      rr_ptr_q,    rr_ptr_d;
    logic                  mem_en_q,    mem_en_d;
    logic                  mem_wr_rd_q, mem_wr_rd_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
    // the command currently on the memory port was rejected as out of range
    logic                  oor_q,       oor_d;

    // per-requester command slices
    logic [ADDR_WIDTH-1:0] req_addr  [NUM_REQ];
    logic [WIDTH-1:0]      req_wdata [NUM_REQ];

    // arbitration
    logic [NUM_REQ-1:0]    eligible;
    logic                  win_found;
    logic [PTR_W-1:0]      win_idx;
    logic [PTR_W-1:0]      cand_idx;
    logic                  win_in_range;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_addr[g]  = bus.addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign req_wdata[g] = bus.wdata[g*WIDTH +: WIDTH];
    end

    // A requester granted this cycle is still holding req; mask it so the same
    // command is not accepted twice.
    assign eligible = bus.req & ~gnt_q;

    // Round-robin search: first eligible requester starting just above rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        cand_idx  = rr_ptr_q;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand_idx = PTR_W'((32'(rr_ptr_q) + off) % NUM_REQ);
            if (!win_found && eligible[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign win_in_range = ({1'b0, req_addr[win_idx]} < DEPTH_EXT);

    // Next-state for grant, pointer, memory command and return strobes.
    always_comb begin
        gnt_d       = '0;
        rr_ptr_d    = rr_ptr_q;
        mem_en_d    = 1'b0;
        oor_d       = 1'b0;
        mem_wr_rd_d = mem_wr_rd_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (win_found) begin
            gnt_d[win_idx] = 1'b1;
            rr_ptr_d       = win_idx;
            mem_wr_rd_d    = bus.wr_rd[win_idx];
            mem_addr_d     = req_addr[win_idx];
            mem_wdata_d    = req_wdata[win_idx];
            mem_en_d       = win_in_range;
            oor_d          = ~win_in_range;
        end

        // gnt_q still identifies the owner of the command now on the memory port,
        // so the return strobes are that one-hot gated by the command type.
        rvalid_d = (mem_en_q && !mem_wr_rd_q) ? gnt_q : '0;
        err_d    = oor_q ? gnt_q : '0;
    end

    // State registers; reset also cancels any in-flight read (mem_en_q cleared).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q       <= '0;
            rvalid_q    <= '0;
            err_q       <= '0;
            rr_ptr_q    <= PTR_RST;
            mem_en_q    <= 1'b0;
            mem_wr_rd_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            oor_q       <= 1'b0;
        end else begin
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            rr_ptr_q    <= rr_ptr_d;
            mem_en_q    <= mem_en_d;
            mem_wr_rd_q <= mem_wr_rd_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            oor_q       <= oor_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.err       = err_q;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_wr_rd = mem_wr_rd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

`ifdef MEM_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] grant_cnt_q, grant_cnt_d;

    // Saturating per-requester grant counters; clear wins over increment.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (stats_clr) begin
                grant_cnt_d[i] = '0;
            end else if (gnt_q[i] && (grant_cnt_q[i] != '1)) begin
                grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
`endif

endmodule
